// File: rtl/edge_waveform_generator.sv
// Converts single-cycle rise/fall request pulses into a held, rate-limited level.
// Optional one-deep queue for an opposite-direction request: define EDGE_GEN_PENDING_EN.
module edge_waveform_generator #(
  parameter int unsigned MIN_HIGH = 4,
  parameter int unsigned MIN_LOW  = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Rise_Req,
  input  logic Fall_Req,
  output logic Y,
  output logic Busy,
  output logic Pending,
  output logic Req_Drop
);

  typedef enum logic [1:0] {
    LOW_IDLE  = 2'd0,
    LOW_HOLD  = 2'd1,
    HIGH_IDLE = 2'd2,
    HIGH_HOLD = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             drop_q, drop_d;
  logic             y_q, y_d;
  logic             busy_q, busy_d;

  logic level;
  logic in_hold;
  logic both_req;
  logic opp_req;
  logic go;
`ifdef EDGE_GEN_PENDING_EN
  logic same_req;
`endif

  // The pending slot only ever holds a request opposite to the current level, so one bit suffices.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    drop_d   = 1'b0;
    go       = 1'b0;
    level    = (state_q == HIGH_IDLE) || (state_q == HIGH_HOLD);
    in_hold  = (state_q == LOW_HOLD) || (state_q == HIGH_HOLD);
    both_req = Rise_Req & Fall_Req;
    opp_req  = !both_req && (level ? Fall_Req : Rise_Req);
`ifdef EDGE_GEN_PENDING_EN
    same_req = !both_req && (level ? Rise_Req : Fall_Req);
`endif

    if (both_req) drop_d = 1'b1;

    if (!in_hold) begin
      go = opp_req;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
`ifdef EDGE_GEN_PENDING_EN
      if (opp_req) begin
        pend_d = 1'b1;
      end else if (same_req && pend_q) begin
        pend_d = 1'b0;
        drop_d = 1'b1;
      end
`else
      if (opp_req) drop_d = 1'b1;
`endif
    end else begin
`ifdef EDGE_GEN_PENDING_EN
      go = opp_req || (pend_q && !same_req);
      if (same_req && pend_q) drop_d = 1'b1;
`else
      go = opp_req;
`endif
      pend_d  = 1'b0;
      state_d = level ? HIGH_IDLE : LOW_IDLE;
    end

    if (go) begin
      state_d = level ? LOW_HOLD : HIGH_HOLD;
      cnt_d   = level ? LOW_LOAD : HIGH_LOAD;
    end

    y_d    = (state_d == HIGH_IDLE) || (state_d == HIGH_HOLD);
    busy_d = (state_d == LOW_HOLD) || (state_d == HIGH_HOLD);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= LOW_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
    end
  end

  assign Y        = y_q;
  assign Busy     = busy_q;
  assign Pending  = pend_q;
  assign Req_Drop = drop_q;

endmodule

// File: tb/tb_edge_waveform_generator.sv
// Scoreboard bench for edge_waveform_generator: time-based reference model plus directed anchors.
module tb_edge_waveform_generator;

  localparam int MH = 4;
  localparam int ML = 3;

  logic Clk = 1'b0;
  logic Rst;
  logic Rise_Req;
  logic Fall_Req;
  logic Y;
  logic Busy;
  logic Pending;
  logic Req_Drop;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] exp_q[$];

  // Reference state: current level, edge index of the last transition, queued request.
  int   m_edge = 0;
  int   m_last = -100000;
  logic m_level = 1'b0;
  logic m_pend  = 1'b0;
  logic m_busy  = 1'b0;
  logic m_drop  = 1'b0;

  edge_waveform_generator #(
    .MIN_HIGH(MH),
    .MIN_LOW (ML),
    .CNT_W   (8)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Rise_Req(Rise_Req),
    .Fall_Req(Fall_Req),
    .Y       (Y),
    .Busy    (Busy),
    .Pending (Pending),
    .Req_Drop(Req_Drop)
  );

  always #5 Clk = ~Clk;

  // A hold started at edge n blocks transitions until edge n+MIN; edge n+MIN is the decision edge.
  task automatic model(input logic rst, input logic r, input logic f);
    int   mn;
    logic both, opp, same, tog;
    if (rst) begin
      m_level = 1'b0;
      m_pend  = 1'b0;
      m_last  = -100000;
      m_drop  = 1'b0;
      m_busy  = 1'b0;
    end else begin
      mn     = m_level ? MH : ML;
      both   = r & f;
      opp    = !both && (m_level ? f : r);
      same   = !both && (m_level ? r : f);
      m_drop = both;
      tog    = 1'b0;
      if (m_edge > m_last + mn) begin
        tog = opp;
      end else if (m_edge < m_last + mn) begin
`ifdef EDGE_GEN_PENDING_EN
        if (opp) m_pend = 1'b1;
        else if (same && m_pend) begin
          m_pend = 1'b0;
          m_drop = 1'b1;
        end
`else
        if (opp) m_drop = 1'b1;
`endif
      end else begin
`ifdef EDGE_GEN_PENDING_EN
        tog = opp || (m_pend && !same);
        if (same && m_pend) m_drop = 1'b1;
`else
        tog = opp;
`endif
        m_pend = 1'b0;
      end
      if (tog) begin
        m_level = ~m_level;
        m_last  = m_edge;
      end
      mn     = m_level ? MH : ML;
      m_busy = (m_edge + 1) <= (m_last + mn);
    end
    m_edge++;
  endtask

  task automatic step(input logic rst, input logic r, input logic f);
    Rst      = rst;
    Rise_Req = r;
    Fall_Req = f;
    model(rst, r, f);
    @(posedge Clk);
    #1;
    exp_q.push_back({m_level, m_busy, m_pend, m_drop});
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a new output set; compare against the queued expectation.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({Y, Busy, Pending, Req_Drop} !== e) begin
          errors++;
          $display("FAIL scoreboard at time %0t: got Y/Busy/Pend/Drop=%b expected %b",
                   $time, {Y, Busy, Pending, Req_Drop}, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1; Rise_Req = 1'b0; Fall_Req = 1'b0;

    // Rise timing: reset cycles 0-1, rise in cycle 3.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_y", Y, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_pend", Pending, 1'b0);
    chk("reset_drop", Req_Drop, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0);
    chk("rise_y", Y, 1'b1);
    chk("rise_busy_first", Busy, 1'b1);
    idle(3);
    chk("rise_busy_last", Busy, 1'b1);
    idle(1);
    chk("rise_busy_off", Busy, 1'b0);
    chk("rise_y_held", Y, 1'b1);

    // Fall from HIGH_IDLE takes effect next cycle.
    step(1'b0, 1'b0, 1'b1);
    chk("fall_y", Y, 1'b0);
    chk("fall_busy", Busy, 1'b1);
    idle(3);
    chk("fall_busy_off", Busy, 1'b0);

    // Opposite request one cycle after a rise.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
`ifdef EDGE_GEN_PENDING_EN
    chk("early_fall_pend", Pending, 1'b1);
    chk("early_fall_nodrop", Req_Drop, 1'b0);
    idle(6);
    chk("early_fall_executed", Y, 1'b0);
`else
    chk("early_fall_drop", Req_Drop, 1'b1);
    chk("early_fall_nopend", Pending, 1'b0);
    idle(6);
    chk("early_fall_y_held", Y, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("late_fall_y", Y, 1'b0);
`endif

    // Simultaneous requests and redundant fall in LOW_IDLE.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("simul_y", Y, 1'b0);
    chk("simul_drop", Req_Drop, 1'b1);
    idle(1);
    chk("simul_drop_pulse", Req_Drop, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("redundant_fall_nodrop", Req_Drop, 1'b0);

    // Cancel: rise, fall, rise on consecutive cycles.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
`ifdef EDGE_GEN_PENDING_EN
    chk("cancel_drop", Req_Drop, 1'b1);
`else
    chk("cancel_same_silent", Req_Drop, 1'b0);
`endif
    chk("cancel_pend", Pending, 1'b0);
    idle(1);
    chk("cancel_drop_pulse", Req_Drop, 1'b0);
    idle(5);
    chk("cancel_y", Y, 1'b1);

    // Reset mid-hold, then rise immediately after.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("midrst_y", Y, 1'b0);
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_pend", Pending, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("post_rst_rise", Y, 1'b1);

    // Randomized traffic, checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 79) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end
    idle(2);

    @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected at most 1", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_waveform_generator.md
# edge_waveform_generator

Level generator that converts single-cycle edge-request pulses into a glitch-free output level. It is the transmit-side counterpart of the edge detector: a `Rise_Req` pulse drives `Y` high and a `Fall_Req` pulse drives it low. Each level is held for a programmable minimum number of cycles. One opposite-direction request can be queued while a hold is in progress. It sits between control logic and any pin or downstream block that needs clean, rate-limited levels.

## Interface
- `MIN_HIGH`, default 4: minimum cycles `Y` stays 1 after rising. Range 1..2^CNT_W.
- `MIN_LOW`, default 4: minimum cycles `Y` stays 0 after falling. Range 1..2^CNT_W.
- `CNT_W`, default 8: hold counter width.
- `Clk` input 1: clock. All state updates on the rising edge.
- `Rst` input 1: reset, synchronous, active-high. Has priority over all requests.
- `Rise_Req` input 1: single-cycle request to drive `Y` high.
- `Fall_Req` input 1: single-cycle request to drive `Y` low.
- `Y` output 1: generated level. Registered.
- `Busy` output 1: high while in a HOLD state.
- `Pending` output 1: queued request is valid.
- `Req_Drop` output 1: one-cycle pulse when a request is discarded or cancelled.

## Operation
- States: LOW_IDLE, LOW_HOLD, HIGH_IDLE, HIGH_HOLD. `Y` = 1 in the HIGH_* states.
- Reset: state LOW_IDLE; `Y`=0, `Busy`=0, `Pending`=0, `Req_Drop`=0, counter=0, pending slot cleared.
- An effective request equal to the current level is ignored. This is silent: no `Req_Drop`.
- `Rise_Req` and `Fall_Req` high in the same cycle: both ignored, `Req_Drop`=1.
- IDLE state with an opposite-level request: toggle `Y`, enter the matching HOLD state, load counter with MIN_x−1 (MIN_x = MIN_HIGH on a rise, MIN_LOW on a fall).
- HOLD state with counter ≠ 0:
  - Counter decrements.
  - An opposite-level request sets `Pending`.
  - A same-level request while `Pending`=1 cancels the pending request: `Pending` clears, `Req_Drop`=1.
- HOLD state with counter = 0:
  - Evaluate the effective request = pending request plus the current-cycle request, after the cancel rule.
  - If an opposite-level request remains: toggle `Y`, reload counter, enter the other HOLD state, clear `Pending`.
  - Otherwise enter the matching IDLE state.
- `Req_Drop` is registered, asserted for exactly one cycle per offending cycle, and 0 otherwise.
- Counter arithmetic is unsigned CNT_W-bit. The counter never underflows: HOLD exits at 0.

## Timing
- Request sampled high at edge n in an IDLE state: `Y` changes at edge n. It is visible during cycle n+1, so latency is 1 cycle.
- After a transition at edge n, the earliest next transition is edge n+MIN_x. The level is therefore held for at least MIN_x cycles.
- A pending request executes exactly at edge n+MIN_x.
- MIN_x = 1: `Y` may toggle every cycle, and HOLD lasts one cycle.
- `Busy` is 1 for cycles n+1..n+MIN_x. It stays 1 continuously if a pending request re-enters HOLD.
- `Rst` asserted at any edge, including mid-HOLD with `Pending` set: all outputs return to their reset values at that edge. A request in the first cycle after `Rst` deasserts is serviced normally.

## Configuration
- Macro: `EDGE_GEN_PENDING_EN`.
- Defined: one-deep pending slot, behaviour as above.
- Undefined:
  - No pending slot.
  - An opposite-level request during HOLD with counter ≠ 0 is discarded with `Req_Drop`=1.
  - At counter = 0, only the current-cycle request is considered.
  - `Pending` is tied to 0.

## Test plan
All scenarios use MIN_HIGH=4, MIN_LOW=3.
- Rise timing: `Rst` cycles 0–1; `Rise_Req` in cycle 3 → `Y`=1 from cycle 4; `Busy`=1 in cycles 4–7; `Busy`=0 in cycle 8; `Y` stays 1.
- Queued fall: `Rise_Req` in cycle 3; `Fall_Req` in cycle 5 → `Pending`=1 in cycles 6–7. `Y` falls at the edge ending cycle 7 (`Y`=0 in cycle 8); `Pending`=0 in cycle 8; `Busy`=1 in cycles 8–10.
- Cancel: rise in cycle 3; `Fall_Req` in cycle 4; `Rise_Req` in cycle 5 → `Pending` 1 then 0 in cycle 6; `Req_Drop`=1 in cycle 6 only; `Y` stays 1.
- Simultaneous: `Rise_Req`=`Fall_Req`=1 in LOW_IDLE → `Y` stays 0; `Req_Drop` pulses for one cycle. A redundant `Fall_Req` in LOW_IDLE → no `Req_Drop`.
- Reset mid-hold: `Rst` asserted during HIGH_HOLD with `Pending`=1 → next cycle `Y`=0, `Busy`=0, `Pending`=0. `Rise_Req` in the first cycle after reset → `Y`=1 in the following cycle.
- Macro undefined: `Fall_Req` one cycle after a rise → `Req_Drop`=1, `Pending`=0, `Y` stays 1 indefinitely. A `Fall_Req` after `Busy` drops → `Y`=0 in the next cycle.
